// File: rtl/spi_status_data_regs.sv
// CPU-facing status/data side of the SPI register file: SPISR flags, SPIDR
// receive/transmit buffers, two-step flag-clear sequences and the interrupt request.
module spi_status_data_regs #(
  parameter logic [2:0] ADDR_CR1 = 3'd0,
  parameter logic [2:0] ADDR_SR  = 3'd3,
  parameter logic [2:0] ADDR_DR  = 3'd5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spe,
  input  logic       spie,
  input  logic       sptie,
  input  logic       mstr,
  input  logic       modfen,
  input  logic       rd_en,
  input  logic       wr_en,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic       xfer_done,
  input  logic [7:0] rx_byte,
  input  logic       tx_load,
  input  logic       mode_fault,
  output logic [7:0] tx_data,
  output logic       tx_pending,
  output logic       spif,
  output logic       sptef,
  output logic       modf,
  output logic       spi_irq
);

  logic [7:0] rdata_q, rdata_d;
  logic [7:0] rx_buf_q, rx_buf_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_pending_q, tx_pending_d;
  logic       spif_q, spif_d;
  logic       sptef_q, sptef_d;
  logic       modf_q, modf_d;
  logic       spif_arm_q, spif_arm_d;
  logic       sptef_arm_q, sptef_arm_d;
  logic       modf_arm_q, modf_arm_d;

  logic       sr_rd, dr_rd, dr_wr, cr1_wr;
  logic       spif_clr, rx_set, tx_acc, tx_rel, modf_set, modf_clr;
  logic [7:0] sr_val;

  always_comb begin
    sr_rd    = rd_en && (addr == ADDR_SR);
    dr_rd    = rd_en && (addr == ADDR_DR);
    dr_wr    = wr_en && (addr == ADDR_DR);
    cr1_wr   = wr_en && (addr == ADDR_CR1);
    sr_val   = {spif_q, 1'b0, sptef_q, modf_q, 4'b0000};

    spif_clr = dr_rd && spif_arm_q;
    // A clearing read that coincides with a new byte still lets the byte in.
    rx_set   = xfer_done && (!spif_q || spif_clr);
    tx_acc   = dr_wr && sptef_q && sptef_arm_q;
    tx_rel   = tx_load && tx_pending_q;
    modf_set = mode_fault && mstr && modfen;
    modf_clr = cr1_wr && modf_arm_q;

    rdata_d      = rdata_q;
    rx_buf_d     = rx_buf_q;
    tx_data_d    = tx_data_q;
    tx_pending_d = tx_pending_q;
    spif_d       = spif_q;
    sptef_d      = sptef_q;
    modf_d       = modf_q;

    if (rd_en) begin
      if (addr == ADDR_SR)      rdata_d = sr_val;
      else if (addr == ADDR_DR) rdata_d = rx_buf_q;
      else                      rdata_d = 8'h00;
    end

    if (rx_set) begin
      spif_d   = 1'b1;
      rx_buf_d = rx_byte;
    end else if (spif_clr) begin
      spif_d = 1'b0;
    end

    if (tx_acc) begin
      tx_data_d    = wdata;
      tx_pending_d = 1'b1;
      sptef_d      = 1'b0;
    end else if (tx_rel) begin
      tx_pending_d = 1'b0;
      sptef_d      = 1'b1;
    end

    if (modf_set)      modf_d = 1'b1;
    else if (modf_clr) modf_d = 1'b0;

    // Each completed clear sequence consumes its arm; a fresh SPISR read is needed.
    spif_arm_d  = spif_d  && !spif_clr && (spif_arm_q  || (sr_rd && spif_q));
    sptef_arm_d = sptef_d && !tx_acc   && (sptef_arm_q || (sr_rd && sptef_q));
    modf_arm_d  = modf_d  && !modf_clr && (modf_arm_q  || (sr_rd && modf_q));

    if (!spe) begin
      rx_buf_d     = rx_buf_q;
      tx_data_d    = tx_data_q;
      spif_d       = 1'b0;
      modf_d       = 1'b0;
      sptef_d      = 1'b1;
      tx_pending_d = 1'b0;
      spif_arm_d   = 1'b0;
      sptef_arm_d  = 1'b0;
      modf_arm_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q      <= 8'h00;
      rx_buf_q     <= 8'h00;
      tx_data_q    <= 8'h00;
      tx_pending_q <= 1'b0;
      spif_q       <= 1'b0;
      sptef_q      <= 1'b1;
      modf_q       <= 1'b0;
      spif_arm_q   <= 1'b0;
      sptef_arm_q  <= 1'b0;
      modf_arm_q   <= 1'b0;
    end else begin
      rdata_q      <= rdata_d;
      rx_buf_q     <= rx_buf_d;
      tx_data_q    <= tx_data_d;
      tx_pending_q <= tx_pending_d;
      spif_q       <= spif_d;
      sptef_q      <= sptef_d;
      modf_q       <= modf_d;
      spif_arm_q   <= spif_arm_d;
      sptef_arm_q  <= sptef_arm_d;
      modf_arm_q   <= modf_arm_d;
    end
  end

  assign rdata      = rdata_q;
  assign tx_data    = tx_data_q;
  assign tx_pending = tx_pending_q;
  assign spif       = spif_q;
  assign sptef      = sptef_q;
  assign modf       = modf_q;
  assign spi_irq    = (spie && (spif_q || modf_q)) || (sptie && sptef_q);

endmodule

// File: tb/tb_spi_status_data_regs.sv
// Bench for spi_status_data_regs: directed scenarios plus a randomized run
// checked against an event-level model of the status/data register rules.
module tb_spi_status_data_regs;

  logic       clk = 1'b0;
  logic       rst, spe, spie, sptie, mstr, modfen;
  logic       rd_en, wr_en, xfer_done, tx_load, mode_fault;
  logic [2:0] addr;
  logic [7:0] wdata, rx_byte;
  logic [7:0] rdata, tx_data;
  logic       tx_pending, spif, sptef, modf, spi_irq;

  int ncmp = 0;
  int nerr = 0;

  spi_status_data_regs dut (
    .clk(clk), .rst(rst), .spe(spe), .spie(spie), .sptie(sptie), .mstr(mstr),
    .modfen(modfen), .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .xfer_done(xfer_done), .rx_byte(rx_byte), .tx_load(tx_load),
    .mode_fault(mode_fault), .tx_data(tx_data), .tx_pending(tx_pending),
    .spif(spif), .sptef(sptef), .modf(modf), .spi_irq(spi_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached (ncmp=%0d)", ncmp);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    rd_en = 0; wr_en = 0; xfer_done = 0; tx_load = 0; mode_fault = 0;
  endtask

  task automatic do_read(input logic [2:0] a);
    rd_en = 1; addr = a; step();
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1; addr = a; wdata = d; step();
  endtask

  task automatic do_xfer(input logic [7:0] b);
    xfer_done = 1; rx_byte = b; step();
  endtask

  task automatic test_reset();
    rst = 1; step(); rst = 0;
    ncmp++; if (rdata !== 8'h00) begin nerr++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    ncmp++; if ({spif, sptef, modf, tx_pending} !== 4'b0100) begin nerr++; $display("FAIL reset_flags: got %b want 0100", {spif, sptef, modf, tx_pending}); end
    ncmp++; if (tx_data !== 8'h00) begin nerr++; $display("FAIL reset_txdata: got %h want 00", tx_data); end
    do_read(3'd3);
    ncmp++; if (rdata !== 8'h20) begin nerr++; $display("FAIL reset_sr_read: got %h want 20", rdata); end
    ncmp++; if (spi_irq !== 1'b0) begin nerr++; $display("FAIL reset_irq_off: got %b want 0", spi_irq); end
    sptie = 1; #1;
    ncmp++; if (spi_irq !== 1'b1) begin nerr++; $display("FAIL reset_irq_sptie: got %b want 1", spi_irq); end
    sptie = 0;
  endtask

  task automatic test_transmit();
    spe = 1; step();
    do_write(3'd5, 8'hA5);
    ncmp++; if (tx_pending !== 1'b0 || tx_data !== 8'h00) begin nerr++; $display("FAIL tx_unarmed_write: pend=%b data=%h want 0/00", tx_pending, tx_data); end
    do_read(3'd3);
    do_write(3'd5, 8'hA5);
    ncmp++; if ({tx_data, tx_pending, sptef} !== {8'hA5, 2'b10}) begin nerr++; $display("FAIL tx_accept: data=%h pend=%b sptef=%b want A5/1/0", tx_data, tx_pending, sptef); end
    step(); step();
    tx_load = 1; step();
    ncmp++; if ({tx_pending, sptef} !== 2'b01) begin nerr++; $display("FAIL tx_load: pend=%b sptef=%b want 0/1", tx_pending, sptef); end
    tx_load = 1; step();
    ncmp++; if ({tx_pending, sptef, tx_data} !== {2'b01, 8'hA5}) begin nerr++; $display("FAIL tx_load_idle: pend=%b sptef=%b data=%h want 0/1/A5", tx_pending, sptef, tx_data); end
  endtask

  task automatic test_receive();
    do_xfer(8'h3C);
    ncmp++; if (spif !== 1'b1) begin nerr++; $display("FAIL rx_set: spif=%b want 1", spif); end
    do_read(3'd5);
    ncmp++; if (rdata !== 8'h3C || spif !== 1'b1) begin nerr++; $display("FAIL rx_unarmed_read: rdata=%h spif=%b want 3C/1", rdata, spif); end
    do_read(3'd3);
    ncmp++; if (rdata !== 8'hA0) begin nerr++; $display("FAIL rx_sr_read: got %h want A0", rdata); end
    do_read(3'd5);
    ncmp++; if (rdata !== 8'h3C || spif !== 1'b0) begin nerr++; $display("FAIL rx_clear: rdata=%h spif=%b want 3C/0", rdata, spif); end
  endtask

  task automatic test_overrun_simul();
    do_xfer(8'h11);
    do_xfer(8'h22);
    do_read(3'd3);
    rd_en = 1; addr = 3'd5; xfer_done = 1; rx_byte = 8'h33; step();
    ncmp++; if (rdata !== 8'h11 || spif !== 1'b1) begin nerr++; $display("FAIL simul_read: rdata=%h spif=%b want 11/1", rdata, spif); end
    do_read(3'd3);
    do_read(3'd5);
    ncmp++; if (rdata !== 8'h33 || spif !== 1'b0) begin nerr++; $display("FAIL simul_rxbuf: rdata=%h spif=%b want 33/0", rdata, spif); end
  endtask

  task automatic test_modf();
    mstr = 1; modfen = 0;
    mode_fault = 1; step();
    ncmp++; if (modf !== 1'b0) begin nerr++; $display("FAIL modf_disabled: modf=%b want 0", modf); end
    modfen = 1;
    mode_fault = 1; step();
    spie = 1; #1;
    ncmp++; if (modf !== 1'b1 || spi_irq !== 1'b1) begin nerr++; $display("FAIL modf_set: modf=%b irq=%b want 1/1", modf, spi_irq); end
    do_write(3'd0, 8'h00);
    ncmp++; if (modf !== 1'b1) begin nerr++; $display("FAIL modf_unarmed_clear: modf=%b want 1", modf); end
    do_read(3'd3);
    ncmp++; if (rdata !== 8'h30) begin nerr++; $display("FAIL modf_sr_read: got %h want 30", rdata); end
    do_write(3'd0, 8'h00);
    ncmp++; if (modf !== 1'b0 || spi_irq !== 1'b0) begin nerr++; $display("FAIL modf_clear: modf=%b irq=%b want 0/0", modf, spi_irq); end
    spie = 0;
  endtask

  task automatic test_disable();
    do_read(3'd3);
    xfer_done = 1; rx_byte = 8'h77; mode_fault = 1; step();
    do_write(3'd5, 8'h5A);
    ncmp++; if ({spif, modf, tx_pending} !== 3'b111) begin nerr++; $display("FAIL dis_setup: spif/modf/pend=%b want 111", {spif, modf, tx_pending}); end
    spe = 0; step(); spe = 1;
    ncmp++; if ({spif, modf, sptef, tx_pending} !== 4'b0010) begin nerr++; $display("FAIL dis_flags: got %b want 0010", {spif, modf, sptef, tx_pending}); end
    ncmp++; if (tx_data !== 8'h5A) begin nerr++; $display("FAIL dis_txdata: got %h want 5A", tx_data); end
    do_read(3'd5);
    ncmp++; if (rdata !== 8'h77) begin nerr++; $display("FAIL dis_rxbuf: got %h want 77", rdata); end
  endtask

  task automatic test_random();
    logic       m_spif, m_sptef, m_modf, m_pend, a_spif, a_sptef, a_modf;
    logic [7:0] m_rx, m_tx, m_rdata;
    logic       rd_clear, wr_ok, cr_clear, sr_look;
    logic       m_irq;
    rst = 1; step(); rst = 0;
    m_spif = 0; m_sptef = 1; m_modf = 0; m_pend = 0; a_spif = 0; a_sptef = 0; a_modf = 0;
    m_rx = 0; m_tx = 0; m_rdata = 0;
    spe = 1; mstr = 1; modfen = 1;
    for (int i = 0; i < 600; i++) begin
      rd_en = ($urandom_range(0, 99) < 45);
      wr_en = ($urandom_range(0, 99) < 30);
      case ($urandom_range(0, 3))
        0: addr = 3'd0;
        1: addr = 3'd3;
        2: addr = 3'd5;
        default: addr = 3'($urandom_range(0, 7));
      endcase
      wdata      = 8'($urandom);
      rx_byte    = 8'($urandom);
      xfer_done  = ($urandom_range(0, 99) < 15);
      tx_load    = ($urandom_range(0, 99) < 15);
      mode_fault = ($urandom_range(0, 99) < 6);
      spe        = ($urandom_range(0, 99) >= 4);
      rst        = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) begin mstr = 1'($urandom); modfen = 1'($urandom); end
      spie  = 1'($urandom);
      sptie = 1'($urandom);

      // Reference behaviour for this cycle, from the register rules.
      if (rd_en) m_rdata = (addr == 3'd3) ? {m_spif, 1'b0, m_sptef, m_modf, 4'b0} :
                           (addr == 3'd5) ? m_rx : 8'h00;
      sr_look  = rd_en && addr == 3'd3;
      rd_clear = rd_en && addr == 3'd5 && a_spif;
      wr_ok    = wr_en && addr == 3'd5 && m_sptef && a_sptef;
      cr_clear = wr_en && addr == 3'd0 && a_modf;
      if (sr_look) begin
        a_spif  = a_spif  | m_spif;
        a_sptef = a_sptef | m_sptef;
        a_modf  = a_modf  | m_modf;
      end
      if (rst) begin
        m_spif = 0; m_sptef = 1; m_modf = 0; m_pend = 0; a_spif = 0; a_sptef = 0; a_modf = 0;
        m_rx = 0; m_tx = 0; m_rdata = 0;
      end else if (!spe) begin
        m_spif = 0; m_sptef = 1; m_modf = 0; m_pend = 0; a_spif = 0; a_sptef = 0; a_modf = 0;
      end else begin
        if (xfer_done && (!m_spif || rd_clear)) begin m_rx = rx_byte; m_spif = 1; end
        else if (rd_clear) m_spif = 0;
        if (rd_clear) a_spif = 0;
        if (wr_ok) begin m_tx = wdata; m_pend = 1; m_sptef = 0; a_sptef = 0; end
        else if (tx_load && m_pend) begin m_pend = 0; m_sptef = 1; end
        if (mode_fault && mstr && modfen) m_modf = 1;
        else if (cr_clear) begin m_modf = 0; a_modf = 0; end
        else if (cr_clear) a_modf = 0;
        if (cr_clear) a_modf = 0;
        if (!m_spif) a_spif = 0;
        if (!m_sptef) a_sptef = 0;
        if (!m_modf) a_modf = 0;
      end
      step();
      rst = 0;
      m_irq = (spie && (m_spif || m_modf)) || (sptie && m_sptef);
      ncmp++; if (rdata !== m_rdata) begin nerr++; $display("FAIL rand_rdata[%0d]: got %h want %h", i, rdata, m_rdata); end
      ncmp++; if ({spif, sptef, modf, tx_pending} !== {m_spif, m_sptef, m_modf, m_pend}) begin nerr++; $display("FAIL rand_flags[%0d]: got %b want %b", i, {spif, sptef, modf, tx_pending}, {m_spif, m_sptef, m_modf, m_pend}); end
      ncmp++; if (tx_data !== m_tx) begin nerr++; $display("FAIL rand_txdata[%0d]: got %h want %h", i, tx_data, m_tx); end
      ncmp++; if (spi_irq !== m_irq) begin nerr++; $display("FAIL rand_irq[%0d]: got %b want %b", i, spi_irq, m_irq); end
    end
  endtask

  initial begin
    rst = 1; spe = 0; spie = 0; sptie = 0; mstr = 0; modfen = 0;
    rd_en = 0; wr_en = 0; xfer_done = 0; tx_load = 0; mode_fault = 0;
    addr = 3'd0; wdata = 8'h00; rx_byte = 8'h00;
    step();
    test_reset();
    test_transmit();
    test_receive();
    test_overrun_simul();
    test_modf();
    test_disable();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/spi_status_data_regs.md
Name: spi_status_data_regs

Overview:
- CPU-facing read side of the SPI register file.
- The control-register block decodes CPU writes into mode bits. This block returns status and data to the CPU.
- Owns SPISR (SPIF, SPTEF, MODF) and the SPIDR receive/transmit buffers. It runs the two-step flag-clear sequences and generates the interrupt request.
- Sits between the CPU bus and the SPI shift engine.

Parameters:
- ADDR_CR1, 3'd0, SPICR1 address (used only to detect writes for the MODF clear)
- ADDR_SR, 3'd3, SPISR address
- ADDR_DR, 3'd5, SPIDR address

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- spe  in  1  SPI enable, from control regs
- spie  in  1  receive/fault interrupt enable
- sptie  in  1  transmit-empty interrupt enable
- mstr  in  1  master mode
- modfen  in  1  mode-fault enable
- rd_en  in  1  CPU read strobe, one cycle
- wr_en  in  1  CPU write strobe, one cycle
- addr  in  3  CPU register address
- wdata  in  8  CPU write data
- rdata  out  8  CPU read data, registered
- xfer_done  in  1  shifter pulse: byte transfer complete
- rx_byte  in  8  received byte, valid with xfer_done
- tx_load  in  1  shifter pulse: takes tx_data this cycle
- mode_fault  in  1  pulse: SS asserted low while in master mode
- tx_data  out  8  transmit buffer contents
- tx_pending  out  1  transmit buffer holds an unsent byte
- spif  out  1  receive-complete flag
- sptef  out  1  transmit-empty flag
- modf  out  1  mode-fault flag
- spi_irq  out  1  interrupt request

Behaviour:
- Reset values (synchronous rst):
  - rdata=0, tx_data=0, rx_buf=0, tx_pending=0.
  - spif=0, sptef=1, modf=0.
  - All arm bits cleared.
- SPISR read value is {spif, 1'b0, sptef, modf, 4'b0}. Reset value is 8'h20.
- Reads:
  - On rd_en, rdata is valid the next cycle.
  - ADDR_SR returns SPISR, ADDR_DR returns rx_buf, any other address returns 0.
  - rdata holds its value when there is no read.
- Arming:
  - A SPISR read sets spif_arm, sptef_arm or modf_arm for each flag that is 1 in that same cycle.
  - An arm bit clears when its flag clears.
- SPIF:
  - Set: xfer_done while spif=0 sets spif and loads rx_buf with rx_byte.
  - Overrun: xfer_done while spif=1 drops rx_byte; rx_buf is unchanged.
  - Clear: an SPIDR read with spif_arm=1 clears spif. rdata still returns the old rx_buf.
  - Simultaneous: if xfer_done and the clearing read occur in the same cycle, the read returns the old buffer, then rx_buf loads rx_byte and spif stays 1 (set wins).
- SPTEF and transmit:
  - Accepted write: an SPIDR write with sptef=1 and sptef_arm=1 loads tx_data, sets tx_pending and clears sptef.
  - Ignored write: any other SPIDR write has no effect.
  - tx_load with tx_pending=1 clears tx_pending and sets sptef. tx_load with tx_pending=0 is ignored.
  - An accepted write requires tx_pending=0, so a write and tx_load never collide.
- MODF:
  - Set: mode_fault sets modf only when spe & mstr & modfen.
  - Clear: a write to ADDR_CR1 with modf_arm=1 clears modf.
  - Simultaneous set and clear in the same cycle: set wins.
- spe=0 (synchronous, every cycle it is low):
  - spif=0, modf=0, sptef=1, tx_pending=0, all arms cleared.
  - rx_buf and tx_data hold their values. CPU reads still work.
- spi_irq is combinational from flops and enables: (spie & (spif | modf)) | (sptie & sptef).
- Reset mid-transfer aborts to reset values. Any later xfer_done or tx_load is handled normally.

Test Plan:
- Reset and idle:
  - Stimulus: rst, then read ADDR_SR.
  - Required: rdata=8'h20 one cycle later; spi_irq=0 with sptie=0; spi_irq=1 after sptie=1.
- Transmit handshake:
  - Stimulus: spe=1; read SR, then write DR 8'hA5; later pulse tx_load.
  - Required: after the write, tx_data=8'hA5, tx_pending=1, sptef=0. After tx_load, sptef=1 and tx_pending=0.
  - Also: a DR write without the prior SR read leaves tx_pending=0.
- Receive and clear:
  - Stimulus: xfer_done with rx_byte=8'h3C, then read SR (rdata=8'h80|8'h20), then read DR.
  - Required: DR read returns 8'h3C and spif clears. A DR read without the prior SR read leaves spif=1.
- Overrun and simultaneous events:
  - Overrun: xfer_done 8'h11, then xfer_done 8'h22 before clearing. Required: rx_buf=8'h11.
  - Simultaneous: after an SR read, a DR read in the same cycle as xfer_done 8'h33. Required: rdata=8'h11, rx_buf=8'h33, spif=1.
- Mode fault:
  - Stimulus: mode_fault with mstr=1, modfen=1.
  - Required: modf=1; spi_irq=1 with spie=1; SR read then CR1 write clears modf.
  - Also: mode_fault with modfen=0 leaves modf=0.
- Disable:
  - Stimulus: with spif=1, modf=1, tx_pending=1, drive spe=0 for one cycle.
  - Required: spif=0, modf=0, sptef=1, tx_pending=0; rx_buf is retained.
